fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-PC fetch path of the CPU top. It keeps a fetch PC and issues word addresses to the synchronous instruction ROM (one-cycle read latency). Returned words are buffered with their PCs in a DEPTH-entry queue and handed to decode over a valid/ready handshake. A redirect input (jump) flushes all stale and in-flight fetches.

Parameters:
ADDR_W, 32, PC width in bits
INST_W, 32, instruction width in bits
ROM_AW, 5, ROM word-address width; rom_addr = pc[ROM_AW+1:2]
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, PC loaded on reset; low 2 bits must be 0

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
rom_addr  out  ROM_AW  word address to the instruction ROM; the ROM registers it at the edge
rom_q  in  INST_W  ROM data for the address presented in the previous cycle
redirect_valid  in  1  jump taken this cycle
redirect_pc  in  ADDR_W  jump target; bits [1:0] are ignored and treated as 0
inst_valid  out  1  queue head valid
inst  out  INST_W  head instruction
inst_pc  out  ADDR_W  head PC
inst_ready  in  1  decode accepts the head this cycle
occupancy  out  $clog2(DEPTH)+1  current queue entry count

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_f=RESET_PC; queue empty; req_d1=0.
  - inst_valid=0, inst=0, inst_pc=0, occupancy=0.
  - rom_addr = RESET_PC word bits.
  - Reset asserted mid-operation discards everything immediately, with no clock edge needed.
- rom_addr is always pc_f[ROM_AW+1:2], combinational from pc_f.
- pop = inst_valid & inst_ready.
- issue = !redirect_valid & (occupancy + req_d1 - pop < DEPTH).
  - On issue: pc_f <= pc_f+4, wrapping modulo 2^ADDR_W.
  - The ROM address wraps by truncation.
- In-flight tracking: req_d1 <= issue and pc_d1 <= pc_f.
  - In the following cycle, if req_d1=1 and redirect_valid=0, {rom_q, pc_d1} is pushed to the queue tail.
- inst_valid = (occupancy != 0) & !redirect_valid.
  - inst and inst_pc show the head entry. When the queue is empty they hold their last value; they are 0 after reset.
- Push and pop in the same cycle: occupancy is unchanged and order is preserved.
  - The credit rule makes push into a full queue impossible.
  - An assertion must flag it.
- Redirect (redirect_valid=1 in cycle t):
  - inst_valid=0 in cycle t; no pop and no push occur.
  - At the edge ending t: queue flushed (occupancy=0), req_d1<=0, pc_f<=redirect_pc & ~3.
  - Target is issued in t+1, its data arrives in t+2, and inst_valid rises in t+3.
  - Back-to-back redirects: the last one wins.
- Latency:
  - Reset release to first inst_valid: 2 cycles.
  - With inst_ready held at 1 and DEPTH>=2: one instruction per cycle, no bubbles.
- Backpressure: while inst_ready=0, the queue fills to DEPTH and issue stops. No word is lost or duplicated.

Decomposition:
- Shared package cpu_pkg holds the default ADDR_W/INST_W, INST_BYTES=4, and the fetch entry struct {inst, pc}.
- One natural sub-module: sync_fifo_flush, a DEPTH x (INST_W+ADDR_W) synchronous FIFO with push, pop, flush and count.
  - Flush has priority over push and pop.
- fetch_queue holds pc_f, req_d1/pc_d1 and the credit logic.

Test Plan:
ROM model: word i = 0x1000_0000+i. All scenarios use DEPTH=4 unless stated.
1. Release rst with inst_ready=1 -> inst_valid first high 2 cycles later with inst=0x10000000, inst_pc=0x0. Then 0x10000001/0x4, 0x10000002/0x8 on consecutive cycles.
2. inst_ready=0 from reset for 10 cycles -> occupancy saturates at 4 and rom_addr stops at 4. Then inst_ready=1 -> words 0..7 delivered in order with no gap and no duplicate.
3. redirect_valid=1 with redirect_pc=0x40 while 3 entries are queued -> inst_valid=0 that cycle and occupancy=0 next cycle. inst_valid returns 3 cycles after redirect with inst=0x10000010, inst_pc=0x40. No pre-redirect word appears afterwards.
4. Redirects in consecutive cycles to 0x20 then 0x63 -> only the stream from pc 0x60 (inst 0x10000018) appears.
5. Wrap with ROM_AW=5: run from pc 0x78 -> inst_pc 0x7C then 0x80, with rom_addr 31 then 0 and inst 0x1000001F then 0x10000000.
6. Assert rst=0 asynchronously between edges while occupancy=3 -> inst_valid, inst, inst_pc and occupancy go to 0 before the next edge. After release, fetch restarts at RESET_PC.
7. DEPTH=2 with inst_ready=1 -> sustained one instruction per cycle over 16 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, instruction size and the
// fetch entry layout buffered between the ROM and decode.
package cpu_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// Synchronous FIFO with a single-cycle flush. Flush wins over push and pop.
// The head entry is presented combinationally on dout.
module sync_fifo_flush #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush & (count != CW'(DEPTH));
  assign do_pop  = pop & ~flush & (count != '0);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and count bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The upstream credit scheme must never deliver a word with no room left.
  assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: walks a fetch PC through a one-cycle-latency
// ROM, buffers returned words with their PCs, and hands them to decode over
// valid/ready. A redirect discards everything queued and in flight.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int ADDR_W                = DEF_ADDR_W,
  parameter int INST_W                = DEF_INST_W,
  parameter int ROM_AW                = 5,
  parameter int DEPTH                 = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [INST_W-1:0]        rom_q,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     inst_valid,
  output logic [INST_W-1:0]        inst,
  output logic [ADDR_W-1:0]        inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] pc_d1;
  logic              req_d1;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       committed;
  logic [INST_W-1:0] head_inst;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] last_inst;
  logic [ADDR_W-1:0] last_pc;
  logic              not_empty;

  assign rom_addr   = pc_f[ROM_AW+1:2];
  assign not_empty  = (occupancy != '0);
  assign inst_valid = not_empty & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;
  assign push       = req_d1 & ~redirect_valid;

  // Entries held plus the word already in flight, minus what leaves now,
  // must stay below DEPTH so the next returned word always has a slot.
  assign committed  = {1'b0, occupancy} + (CW+1)'(req_d1) - (CW+1)'(pop);
  assign issue      = ~redirect_valid & (committed < (CW+1)'(DEPTH));

  // With the queue empty the head slot holds stale data, so show the last
  // delivered entry instead.
  assign inst    = not_empty ? head_inst : last_inst;
  assign inst_pc = not_empty ? head_pc   : last_pc;

  // Fetch PC and in-flight request tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f   <= RESET_PC;
      pc_d1  <= '0;
      req_d1 <= 1'b0;
    end else begin
      req_d1 <= issue;
      pc_d1  <= pc_f;
      if (redirect_valid)
        pc_f <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (issue)
        pc_f <= pc_f + ADDR_W'(INST_BYTES);
    end
  end

  // Remember the head on display so it can be held once the queue drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_inst <= '0;
      last_pc   <= '0;
    end else if (not_empty) begin
      last_inst <= head_inst;
      last_pc   <= head_pc;
    end
  end

  sync_fifo_flush #(
    .WIDTH (INST_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({rom_q, pc_d1}),
    .dout  ({head_inst, head_pc}),
    .count (occupancy)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a DEPTH=4 instance checked by a scoreboard on every
// decode handshake plus directed timing checks, and a DEPTH=2 instance for
// sustained throughput.
module tb_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DEPTH=4 instance
  logic        rst;
  logic [4:0]  rom_addr;
  logic [31:0] rom_q;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  occupancy;

  // DEPTH=2 instance
  logic        rst2;
  logic [4:0]  rom_addr2;
  logic [31:0] rom_q2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        inst_valid2;
  logic [31:0] inst2;
  logic [31:0] inst_pc2;
  logic        inst_ready2;
  logic [1:0]  occupancy2;

  fetch_queue #(.ADDR_W(32), .INST_W(32), .ROM_AW(5), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_q(rom_q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .occupancy(occupancy)
  );

  fetch_queue #(.ADDR_W(32), .INST_W(32), .ROM_AW(5), .DEPTH(2), .RESET_PC(32'h0)) dut2 (
    .clk(clk), .rst(rst2), .rom_addr(rom_addr2), .rom_q(rom_q2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
    .inst_ready(inst_ready2), .occupancy(occupancy2)
  );

  // ROM models: word i = 0x1000_0000 + i, one-cycle registered read.
  always @(posedge clk) rom_q  <= 32'h1000_0000 + {27'd0, rom_addr};
  always @(posedge clk) rom_q2 <= 32'h1000_0000 + {27'd0, rom_addr2};

  function automatic logic [31:0] exp_word(logic [31:0] pc);
    return 32'h1000_0000 + {27'd0, pc[6:2]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected delivery stream: consecutive PCs starting at pc0.
  logic [31:0] exp_q[$];
  task automatic exp_start(logic [31:0] pc0);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(pc0 + 32'(4 * i));
  endtask

  // Scoreboard monitor: every accepted head must be the next expected entry.
  logic [31:0] sb_pc;
  always @(negedge clk) begin
    if (rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual_pc=%h required=no_delivery", inst_pc);
      end else begin
        sb_pc = exp_q.pop_front();
        chk("sb_pc", inst_pc, sb_pc);
        chk("sb_inst", inst, exp_word(sb_pc));
      end
    end
  end

  initial begin
    rst = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    rst2 = 1'b0; inst_ready2 = 1'b1; redirect_valid2 = 1'b0; redirect_pc2 = 32'h0;
    exp_start(32'h0);
    step(2);

    // Reset state
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);

    // 1: first instruction two cycles after release, then one per cycle
    rst = 1'b1;
    step(1);
    chk("s1_valid_c1", 32'(inst_valid), 32'd0);
    step(1);
    chk("s1_valid_c2", 32'(inst_valid), 32'd1);
    chk("s1_inst0", inst, 32'h1000_0000);
    chk("s1_pc0", inst_pc, 32'h0);
    step(1);
    chk("s1_inst1", inst, 32'h1000_0001);
    chk("s1_pc1", inst_pc, 32'h4);
    step(1);
    chk("s1_inst2", inst, 32'h1000_0002);
    chk("s1_pc2", inst_pc, 32'h8);

    // 2: backpressure from reset, then drain without gaps
    rst = 1'b0; inst_ready = 1'b0;
    exp_start(32'h0);
    step(1);
    rst = 1'b1;
    step(10);
    chk("s2_occ_full", 32'(occupancy), 32'd4);
    chk("s2_rom_addr", 32'(rom_addr), 32'd4);
    inst_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("s2_valid", 32'(inst_valid), 32'd1);
      chk("s2_pc", inst_pc, 32'(4 * i));
      step(1);
    end

    // 3: redirect with three entries queued
    rst = 1'b0; inst_ready = 1'b0;
    step(1);
    rst = 1'b1;
    step(4);
    chk("s3_occ3", 32'(occupancy), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
    exp_start(32'h40);
    #1;
    chk("s3_valid_t", 32'(inst_valid), 32'd0);
    step(1);
    redirect_valid = 1'b0;
    #1;
    chk("s3_occ_t1", 32'(occupancy), 32'd0);
    chk("s3_valid_t1", 32'(inst_valid), 32'd0);
    step(1);
    chk("s3_valid_t2", 32'(inst_valid), 32'd0);
    step(1);
    chk("s3_valid_t3", 32'(inst_valid), 32'd1);
    chk("s3_inst", inst, 32'h1000_0010);
    chk("s3_pc", inst_pc, 32'h40);
    step(4);

    // 4: back-to-back redirects, last wins, low target bits ignored
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    exp_start(32'h60);
    step(1);
    redirect_pc = 32'h63;
    #1;
    chk("s4_valid_t1", 32'(inst_valid), 32'd0);
    step(1);
    redirect_valid = 1'b0;
    #1;
    chk("s4_valid_t2", 32'(inst_valid), 32'd0);
    step(1);
    chk("s4_valid_t3", 32'(inst_valid), 32'd0);
    step(1);
    chk("s4_valid_t4", 32'(inst_valid), 32'd1);
    chk("s4_inst", inst, 32'h1000_0018);
    chk("s4_pc", inst_pc, 32'h60);
    step(3);

    // 5: ROM address wraps by truncation
    redirect_valid = 1'b1; redirect_pc = 32'h78;
    exp_start(32'h78);
    step(1);
    redirect_valid = 1'b0;
    #1;
    chk("s5_rom_addr_t1", 32'(rom_addr), 32'd30);
    step(1);
    chk("s5_rom_addr_t2", 32'(rom_addr), 32'd31);
    step(1);
    chk("s5_rom_addr_t3", 32'(rom_addr), 32'd0);
    chk("s5_pc78", inst_pc, 32'h78);
    step(1);
    chk("s5_inst7c", inst, 32'h1000_001F);
    chk("s5_pc7c", inst_pc, 32'h7C);
    step(1);
    chk("s5_inst80", inst, 32'h1000_0000);
    chk("s5_pc80", inst_pc, 32'h80);

    // 6: asynchronous reset mid-cycle with three entries queued
    rst = 1'b0; inst_ready = 1'b0;
    step(1);
    rst = 1'b1;
    step(4);
    chk("s6_occ3", 32'(occupancy), 32'd3);
    chk("s6_head", inst, 32'h1000_0000);
    #3;
    rst = 1'b0;
    #1;
    chk("s6_async_valid", 32'(inst_valid), 32'd0);
    chk("s6_async_inst", inst, 32'h0);
    chk("s6_async_pc", inst_pc, 32'h0);
    chk("s6_async_occ", 32'(occupancy), 32'd0);
    chk("s6_async_rom_addr", 32'(rom_addr), 32'd0);
    inst_ready = 1'b1;
    exp_start(32'h0);
    step(1);
    rst = 1'b1;
    step(2);
    chk("s6_restart_valid", 32'(inst_valid), 32'd1);
    chk("s6_restart_pc", inst_pc, 32'h0);
    step(3);

    // 7: DEPTH=2 sustains one instruction per cycle
    rst2 = 1'b1;
    step(2);
    for (int i = 0; i < 16; i++) begin
      chk("s7_valid", 32'(inst_valid2), 32'd1);
      chk("s7_pc", inst_pc2, 32'(4 * i));
      chk("s7_inst", inst2, 32'h1000_0000 + 32'(i));
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
